// File: rtl/ibex_sram_bridge.sv
// Bridges one Ibex req/gnt/rvalid memory port onto a single-port synchronous SRAM macro
// (active-low CEN/WEN, Q one cycle after the access); partial stores become read-modify-write.
module ibex_sram_bridge #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_LSB  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              mem_cen_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned TAG_LSB = ADDR_W + ADDR_LSB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    RMW  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic [ADDR_W-1:0] rmw_index_reg, rmw_index_next;
  logic [31:0]       rmw_wdata_reg, rmw_wdata_next;
  logic [3:0]        rmw_be_reg, rmw_be_next;
  logic              resp_read_reg, resp_read_next;
  logic              resp_err_reg, resp_err_next;

  logic              in_range;
  logic [ADDR_W-1:0] req_index;
  logic [31:0]       merged_wdata;
  logic              mem_access;
  logic              mem_write;
  logic              unused_addr;

  assign in_range    = (addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign req_index   = addr_i[TAG_LSB-1:ADDR_LSB];
  assign unused_addr = ^addr_i[ADDR_LSB-1:0];

  // Second half of a partial store: enabled bytes from the latched store data,
  // the rest from the word the macro returned for the first-half read.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_wdata[8*gi +: 8] = rmw_be_reg[gi] ? rmw_wdata_reg[8*gi +: 8]
                                                    : mem_rdata_i[8*gi +: 8];
  end

  always_comb begin
    state_next     = state_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rmw_index_next = rmw_index_reg;
    rmw_wdata_next = rmw_wdata_reg;
    rmw_be_next    = rmw_be_reg;
    resp_read_next = 1'b0;
    resp_err_next  = 1'b0;
    mem_access     = 1'b0;
    mem_write      = 1'b0;
    gnt_o          = req_i && (state_reg == IDLE || state_reg == RESP) && !rst_i;

    if (!rst_i) begin
      unique case (state_reg)
        RMW: begin
          mem_access     = 1'b1;
          mem_write      = 1'b1;
          mem_addr_next  = rmw_index_reg;
          mem_wdata_next = merged_wdata;
          state_next     = RESP;
        end
        default: begin
          // IDLE and RESP behave alike: RESP simply accepts the next request early.
          state_next = IDLE;
          if (gnt_o) begin
            state_next = RESP;
            if (!in_range) begin
              resp_err_next = 1'b1;
            end else if (!we_i) begin
              mem_access     = 1'b1;
              mem_addr_next  = req_index;
              resp_read_next = 1'b1;
            end else if (be_i == 4'b1111) begin
              mem_access     = 1'b1;
              mem_write      = 1'b1;
              mem_addr_next  = req_index;
              mem_wdata_next = wdata_i;
            end else if (be_i != 4'b0000) begin
              mem_access     = 1'b1;
              mem_addr_next  = req_index;
              rmw_index_next = req_index;
              rmw_wdata_next = wdata_i;
              rmw_be_next    = be_i;
              state_next     = RMW;
            end
          end
        end
      endcase
    end
  end

  // Address/data follow the access combinationally and otherwise hold the last driven value.
  assign mem_cen_o   = !mem_access;
  assign mem_wen_o   = !mem_write;
  assign mem_addr_o  = mem_addr_next;
  assign mem_wdata_o = mem_wdata_next;

  assign rvalid_o = (state_reg == RESP) && !rst_i;
  assign rdata_o  = (rvalid_o && resp_read_reg) ? mem_rdata_i : 32'h0;
  assign err_o    = rvalid_o && resp_err_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rmw_index_reg <= '0;
      rmw_wdata_reg <= '0;
      rmw_be_reg    <= '0;
      resp_read_reg <= 1'b0;
      resp_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rmw_index_reg <= rmw_index_next;
      rmw_wdata_reg <= rmw_wdata_next;
      rmw_be_reg    <= rmw_be_next;
      resp_read_reg <= resp_read_next;
      resp_err_reg  <= resp_err_next;
    end
  end

endmodule

// File: tb/tb_ibex_sram_bridge.sv
// Randomised bench for ibex_sram_bridge: SRAM macro model plus a transaction-level reference.
module tb_ibex_sram_bridge;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o, mem_cen_o, mem_wen_o;
  logic [31:0] rdata_o, mem_wdata_o, mem_rdata_i;
  logic [7:0]  mem_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibex_sram_bridge #(.ADDR_W(8), .BASE_ADDR(32'h0), .ADDR_LSB(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .err_o(err_o), .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hCAFE_F00D;
    if (i == 5) return 32'h1122_3344;
    return {8'(i), 8'hA5, 8'(i ^ 8'h3C), 8'h5A};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM macro: Q registered one cycle after a read access
  logic [31:0] sram [DEPTH];
  bit          sram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
      sram_loaded <= 1'b1;
    end else if (mem_cen_o === 1'b0) begin
      if (mem_wen_o === 1'b0) sram[mem_addr_o] <= mem_wdata_o;
      else mem_rdata_i <= sram[mem_addr_o];
    end
  end

  // Reference model: memory image, scheduled responses, pending RMW write-back
  typedef struct { int due; logic [31:0] rdata; logic err; } resp_t;
  logic [31:0] ref_mem [DEPTH];
  bit          ref_loaded = 1'b0;
  resp_t       rq[$];
  bit          rmw_pend = 1'b0;
  int          rmw_due = 0;
  logic [7:0]  rmw_idx = '0;
  logic [31:0] rmw_word = '0;
  logic [7:0]  last_addr = '0;
  int          cyc = 0;

  always @(negedge clk) begin
    logic        exp_rv, exp_access, oor;
    logic [7:0]  idx;
    logic [31:0] word;
    if (!ref_loaded) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      ref_loaded = 1'b1;
    end
    cyc++;
    if (rst_i) begin
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_cen", 32'(mem_cen_o), 32'd1);
      chk("rst_wen", 32'(mem_wen_o), 32'd1);
      chk("rst_rvalid", 32'(rvalid_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      rq.delete();
      rmw_pend  = 1'b0;
      last_addr = '0;
    end else begin
      exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
      chk("rvalid", 32'(rvalid_o), 32'(exp_rv));
      if (exp_rv) begin
        chk("rdata", rdata_o, rq[0].rdata);
        chk("err", 32'(err_o), 32'(rq[0].err));
        $display("resp cyc=%0d rdata=%h err=%b", cyc, rdata_o, err_o);
        void'(rq.pop_front());
      end else begin
        chk("rdata_idle", rdata_o, 32'd0);
        chk("err_idle", 32'(err_o), 32'd0);
      end
      exp_access = 1'b0;
      if (rmw_pend && rmw_due == cyc) begin
        chk("rmw_gnt", 32'(gnt_o), 32'd0);
        chk("rmw_cen", 32'(mem_cen_o), 32'd0);
        chk("rmw_wen", 32'(mem_wen_o), 32'd0);
        chk("rmw_addr", 32'(mem_addr_o), 32'(rmw_idx));
        chk("rmw_wdata", mem_wdata_o, rmw_word);
        ref_mem[rmw_idx] = rmw_word;
        last_addr  = rmw_idx;
        rmw_pend   = 1'b0;
        exp_access = 1'b1;
      end else if (req_i) begin
        chk("gnt", 32'(gnt_o), 32'd1);
        oor = (addr_i[31:10] != 22'd0);
        idx = addr_i[9:2];
        if (oor) begin
          rq.push_back('{cyc + 1, 32'd0, 1'b1});
        end else if (!we_i || be_i != 4'b0000) begin
          exp_access = 1'b1;
          last_addr  = idx;
          chk("acc_cen", 32'(mem_cen_o), 32'd0);
          chk("acc_addr", 32'(mem_addr_o), 32'(idx));
          if (!we_i) begin
            chk("rd_wen", 32'(mem_wen_o), 32'd1);
            rq.push_back('{cyc + 1, ref_mem[idx], 1'b0});
          end else if (be_i == 4'b1111) begin
            chk("wr_wen", 32'(mem_wen_o), 32'd0);
            chk("wr_wdata", mem_wdata_o, wdata_i);
            ref_mem[idx] = wdata_i;
            rq.push_back('{cyc + 1, 32'd0, 1'b0});
          end else begin
            chk("rmwrd_wen", 32'(mem_wen_o), 32'd1);
            word = ref_mem[idx];
            for (int k = 0; k < 4; k++)
              if (be_i[k]) word[8*k +: 8] = wdata_i[8*k +: 8];
            rmw_pend = 1'b1;
            rmw_due  = cyc + 1;
            rmw_idx  = idx;
            rmw_word = word;
            rq.push_back('{cyc + 2, 32'd0, 1'b0});
          end
        end else begin
          rq.push_back('{cyc + 1, 32'd0, 1'b0});
        end
      end else begin
        chk("gnt_idle", 32'(gnt_o), 32'd0);
      end
      if (!exp_access) begin
        chk("noacc_cen", 32'(mem_cen_o), 32'd1);
        chk("noacc_wen", 32'(mem_wen_o), 32'd1);
        chk("hold_addr", 32'(mem_addr_o), 32'(last_addr));
      end
    end
  end

  task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(posedge clk); #1;
    req_i = 1'b1; we_i = w; be_i = b; addr_i = a; wdata_i = d;
    n = 0;
    @(negedge clk);
    while (!gnt_o && n < 20) begin @(negedge clk); n++; end
    chk("gnt_wait", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rvalid_o && lat < 20) begin @(negedge clk); lat++; end
    chk("rvalid_wait", 32'(rvalid_o), 32'd1);
    rd = rdata_o;
    er = err_o;
    $display("txn we=%b be=%b addr=%h wdata=%h -> rdata=%h err=%b lat=%0d", w, b, a, d, rd, er, lat);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        g;
    rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h10; wdata_i = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_rst_gnt", 32'(gnt_o), 32'd0);
      chk("lit_rst_cen", 32'(mem_cen_o), 32'd1);
      chk("lit_rst_rvalid", 32'(rvalid_o), 32'd0);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("lit_rd_gnt", 32'(gnt_o), 32'd1);
    chk("lit_rd_addr", 32'(mem_addr_o), 32'h04);
    chk("lit_wdata_reset", mem_wdata_o, 32'd0);
    @(posedge clk); #1;
    req_i = 1'b0;
    @(negedge clk);
    chk("lit_rd_rvalid", 32'(rvalid_o), 32'd1);
    chk("lit_rd_data", rdata_o, 32'hCAFE_F00D);

    // back-to-back full-word stores
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h20; wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lit_b2b_gnt0", 32'(gnt_o), 32'd1);
    chk("lit_b2b_wen0", 32'(mem_wen_o), 32'd0);
    @(posedge clk); #1;
    addr_i = 32'h24; wdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("lit_b2b_gnt1", 32'(gnt_o), 32'd1);
    chk("lit_b2b_rv0", 32'(rvalid_o), 32'd1);
    chk("lit_b2b_addr1", 32'(mem_addr_o), 32'h09);
    @(posedge clk); #1;
    req_i = 1'b0;
    @(negedge clk);
    chk("lit_b2b_rv1", 32'(rvalid_o), 32'd1);
    access(1'b0, 4'hF, 32'h20, 32'h0, rd, er, lat);
    chk("lit_rb_20", rd, 32'hDEAD_BEEF);
    access(1'b0, 4'hF, 32'h24, 32'h0, rd, er, lat);
    chk("lit_rb_24", rd, 32'h1234_5678);

    // partial store with a read queued behind it
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; be_i = 4'b0101; addr_i = 32'h14; wdata_i = 32'hAABB_CCDD;
    @(negedge clk);
    chk("lit_pw_gnt", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    we_i = 1'b0;
    @(negedge clk);
    chk("lit_pw_gnt_rmw", 32'(gnt_o), 32'd0);
    chk("lit_pw_wdata", mem_wdata_o, 32'h11BB_33DD);
    chk("lit_pw_rv_rmw", 32'(rvalid_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_pw_rv", 32'(rvalid_o), 32'd1);
    chk("lit_raw_gnt", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0;
    @(negedge clk);
    chk("lit_raw_data", rdata_o, 32'h11BB_33DD);

    // out of range, then empty byte-enable store
    access(1'b0, 4'hF, 32'h0000_0400, 32'h0, rd, er, lat);
    chk("lit_oor_err", 32'(er), 32'd1);
    chk("lit_oor_rdata", rd, 32'd0);
    chk("lit_oor_lat", 32'(lat), 32'd1);
    access(1'b1, 4'b0000, 32'h14, 32'hFFFF_FFFF, rd, er, lat);
    chk("lit_be0_err", 32'(er), 32'd0);
    chk("lit_be0_lat", 32'(lat), 32'd1);
    access(1'b0, 4'hF, 32'h14, 32'h0, rd, er, lat);
    chk("lit_be0_mem", rd, 32'h11BB_33DD);

    // reset during the write-back half of a partial store
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; be_i = 4'b0011; addr_i = 32'h10; wdata_i = 32'h0;
    @(negedge clk);
    chk("lit_rr_gnt", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    chk("lit_rr_cen", 32'(mem_cen_o), 32'd1);
    chk("lit_rr_rv", 32'(rvalid_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("lit_rr_rv_after", 32'(rvalid_o), 32'd0);
    access(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
    chk("lit_rr_mem", rd, 32'hCAFE_F00D);

    // randomised traffic; request fields held until granted
    g = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      g = gnt_o;
      @(posedge clk); #1;
      rst_i = ($urandom_range(0, 149) == 0);
      if (!req_i || g) begin
        req_i = ($urandom_range(0, 3) != 0);
        we_i  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       be_i = 4'hF;
          1:       be_i = 4'h0;
          default: be_i = 4'($urandom);
        endcase
        wdata_i = $urandom;
        if ($urandom_range(0, 9) == 0) addr_i = $urandom | 32'h400;
        else addr_i = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom)};
      end
    end
    @(posedge clk); #1;
    req_i = 1'b0; rst_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) chk("mem_final", sram[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
